// File: rtl/dda_move_engine.sv
// Buffered multi-axis second-order DDA move executor; a queued move loads 2 cycles after the previous one ends.
// wr_ready drops when the FIFO is full (from registered count) or while abort is high.
module dda_move_engine #(
  parameter int          NUM_AXES     = 2,
  parameter int          BUFFER_DEPTH = 4,
  parameter int          DUR_WIDTH    = 64,
  parameter int          ACC_WIDTH    = 64,
  parameter int          DIV_WIDTH    = 24,
  parameter logic [63:0] THRESHOLD    = 64'h7fffffffffffff9b,
  parameter int          STEP_HOLD    = 8
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [DIV_WIDTH-1:0]            clock_divisor,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [DUR_WIDTH-1:0]            wr_duration,
  input  logic [NUM_AXES-1:0]             wr_dir,
  input  logic [NUM_AXES*ACC_WIDTH-1:0]   wr_increment,
  input  logic [NUM_AXES*ACC_WIDTH-1:0]   wr_incinc,
  input  logic                            abort,
  output logic [NUM_AXES-1:0]             step,
  output logic [NUM_AXES-1:0]             dir,
  output logic                            busy,
  output logic                            move_done,
  output logic [$clog2(BUFFER_DEPTH):0]   buffer_count
);

  localparam int PTR_W  = $clog2(BUFFER_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = $clog2(STEP_HOLD + 1);
  localparam logic [ACC_WIDTH-1:0] THR = THRESHOLD[ACC_WIDTH-1:0];

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
  state_t state;

  logic [DUR_WIDTH-1:0]          mem_dur    [BUFFER_DEPTH];
  logic [NUM_AXES-1:0]           mem_dir    [BUFFER_DEPTH];
  logic [NUM_AXES*ACC_WIDTH-1:0] mem_inc    [BUFFER_DEPTH];
  logic [NUM_AXES*ACC_WIDTH-1:0] mem_incinc [BUFFER_DEPTH];
  logic [PTR_W-1:0]              rd_ptr, wr_ptr;

  logic [DUR_WIDTH-1:0]          cur_dur, tickdown;
  logic [NUM_AXES-1:0]           cur_dir;
  logic [NUM_AXES*ACC_WIDTH-1:0] cur_inc, cur_incinc;
  logic [DIV_WIDTH-1:0]          div_r, clkcnt;
  logic                          first;
  logic [ACC_WIDTH-1:0]          inc_r   [NUM_AXES];
  logic [ACC_WIDTH-1:0]          acc     [NUM_AXES];
  logic [ACC_WIDTH-1:0]          inc_nx  [NUM_AXES];
  logic [ACC_WIDTH-1:0]          acc_sum [NUM_AXES];
  logic [HOLD_W-1:0]             hcnt    [NUM_AXES];
  logic [NUM_AXES-1:0]           pend, fire;
  logic                          push, pop, tick;

  assign wr_ready = (buffer_count < CNT_W'(BUFFER_DEPTH)) && !abort;
  assign push     = wr_valid && wr_ready;
  assign pop      = (state == S_IDLE) && (buffer_count != '0);
  assign tick     = (state == S_RUN) && ((clkcnt + DIV_WIDTH'(1)) == div_r);
  assign busy     = (state != S_IDLE);

  always_comb begin
    fire = '0;
    for (int a = 0; a < NUM_AXES; a++) begin
      inc_nx[a]  = first ? inc_r[a] : inc_r[a] + cur_incinc[a*ACC_WIDTH +: ACC_WIDTH];
      acc_sum[a] = acc[a] + inc_nx[a];
      // strictly positive in two's complement
      fire[a]    = tick && !acc_sum[a][ACC_WIDTH-1] && (acc_sum[a] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dur[wr_ptr]    <= wr_duration;
      mem_dir[wr_ptr]    <= wr_dir;
      mem_inc[wr_ptr]    <= wr_increment;
      mem_incinc[wr_ptr] <= wr_incinc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      buffer_count <= '0;
      move_done    <= 1'b0;
      dir          <= '0;
      step         <= '0;
      pend         <= '0;
      tickdown     <= '0;
      div_r        <= DIV_WIDTH'(1);
      clkcnt       <= '0;
      first        <= 1'b0;
      cur_dur      <= '0;
      cur_dir      <= '0;
      cur_inc      <= '0;
      cur_incinc   <= '0;
      for (int a = 0; a < NUM_AXES; a++) begin
        acc[a]   <= '0;
        inc_r[a] <= '0;
        hcnt[a]  <= '0;
      end
    end else if (abort) begin
      state        <= S_IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      buffer_count <= '0;
      move_done    <= 1'b0;
      step         <= '0;
      pend         <= '0;
      for (int a = 0; a < NUM_AXES; a++) begin
        acc[a]  <= '0;
        hcnt[a] <= '0;
      end
    end else begin
      move_done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      buffer_count <= buffer_count + 1'b1;
      else if (pop && !push) buffer_count <= buffer_count - 1'b1;

      // A tick landing on a live pulse forces a one-cycle low so each step is its own edge.
      for (int a = 0; a < NUM_AXES; a++) begin
        if (fire[a]) begin
          if (step[a] || pend[a]) begin
            step[a] <= 1'b0;
            pend[a] <= 1'b1;
          end else begin
            step[a] <= 1'b1;
            hcnt[a] <= HOLD_W'(STEP_HOLD);
          end
        end else if (pend[a]) begin
          pend[a] <= 1'b0;
          step[a] <= 1'b1;
          hcnt[a] <= HOLD_W'(STEP_HOLD);
        end else if (step[a]) begin
          if (hcnt[a] == HOLD_W'(1)) step[a] <= 1'b0;
          hcnt[a] <= hcnt[a] - 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (pop) begin
            cur_dur    <= mem_dur[rd_ptr];
            cur_dir    <= mem_dir[rd_ptr];
            cur_inc    <= mem_inc[rd_ptr];
            cur_incinc <= mem_incinc[rd_ptr];
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          tickdown <= cur_dur;
          div_r    <= (clock_divisor == '0) ? DIV_WIDTH'(1) : clock_divisor;
          dir      <= cur_dir;
          first    <= 1'b1;
          clkcnt   <= '0;
          for (int a = 0; a < NUM_AXES; a++) inc_r[a] <= cur_inc[a*ACC_WIDTH +: ACC_WIDTH];
          if (cur_dur == '0) begin
            move_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          clkcnt <= tick ? '0 : clkcnt + 1'b1;
          if (tick) begin
            first    <= 1'b0;
            tickdown <= tickdown - 1'b1;
            for (int a = 0; a < NUM_AXES; a++) begin
              inc_r[a] <= inc_nx[a];
              acc[a]   <= fire[a] ? acc_sum[a] - THR : acc_sum[a];
            end
            if (tickdown == DUR_WIDTH'(1)) begin
              move_done <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dda_move_engine.sv
// Directed bench for dda_move_engine with a DDA reference model feeding a per-move scoreboard.
module tb_dda_move_engine;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  clock_divisor;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_duration;
  logic [1:0]  wr_dir;
  logic [31:0] wr_increment;
  logic [31:0] wr_incinc;
  logic        abort;
  logic [1:0]  step;
  logic [1:0]  dir;
  logic        busy;
  logic        move_done;
  logic [2:0]  buffer_count;

  dda_move_engine #(
    .NUM_AXES(2), .BUFFER_DEPTH(4), .DUR_WIDTH(16), .ACC_WIDTH(16),
    .DIV_WIDTH(8), .THRESHOLD(64'd100), .STEP_HOLD(2)
  ) dut (
    .clk(clk), .resetn(resetn), .clock_divisor(clock_divisor),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_duration(wr_duration),
    .wr_dir(wr_dir), .wr_increment(wr_increment), .wr_incinc(wr_incinc),
    .abort(abort), .step(step), .dir(dir), .busy(busy),
    .move_done(move_done), .buffer_count(buffer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cnt0;
    int          cnt1;
    logic [31:0] mask0;
    logic [31:0] mask1;
    logic [1:0]  dir;
    int          lat;
    int          div;
  } exp_t;

  exp_t               sbq[$];
  logic signed [15:0] macc [2];
  int                 cur_div;
  int                 total = 0;
  int                 bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference DDA: walks the move tick by tick from the model accumulators.
  task automatic model_move(input logic [15:0] dur, input logic [1:0] d,
                            input logic signed [15:0] i0, ii0, i1, ii1);
    exp_t               e;
    logic signed [15:0] inc [2];
    logic signed [15:0] iiv [2];
    int                 c [2];
    logic [31:0]        m [2];
    inc[0] = i0; inc[1] = i1; iiv[0] = ii0; iiv[1] = ii1;
    c[0] = 0; c[1] = 0; m[0] = '0; m[1] = '0;
    for (int t = 1; t <= int'(dur); t++) begin
      for (int a = 0; a < 2; a++) begin
        if (t > 1) inc[a] = inc[a] + iiv[a];
        macc[a] = macc[a] + inc[a];
        if (macc[a] > 16'sd0) begin
          c[a]++;
          if (t <= 32) m[a][t-1] = 1'b1;
          macc[a] = macc[a] - 16'sd100;
        end
      end
    end
    e.cnt0 = c[0]; e.cnt1 = c[1]; e.mask0 = m[0]; e.mask1 = m[1];
    e.dir = d; e.lat = int'(dur) * cur_div + 1; e.div = cur_div;
    sbq.push_back(e);
  endtask

  task automatic push_move(input logic [15:0] dur, input logic [1:0] d,
                           input logic signed [15:0] i0, ii0, i1, ii1);
    bit ok = 0;
    @(negedge clk);
    wr_duration = dur; wr_dir = d;
    wr_increment = {i1, i0}; wr_incinc = {ii1, ii0};
    wr_valid = 1'b1;
    #1;
    for (int k = 0; k < 300; k++) begin
      if (wr_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    #1 wr_valid = 1'b0;
    chk("push_accept", 64'(ok), 64'd1);
    if (ok) model_move(dur, d, i0, ii0, i1, ii1);
  endtask

  task automatic wait_busy();
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (busy) begin ok = 1; break; end
    end
    chk("wait_busy", 64'(ok), 64'd1);
  endtask

  task automatic wait_md();
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (move_done) begin ok = 1; break; end
    end
    chk("wait_move_done", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !busy) begin ok = 1; break; end
    end
    chk("drain", 64'(ok), 64'd1);
  endtask

  // Per-move monitor: step edges, tick positions, latency, dir and load gap.
  int          cyc = 0, load_cyc = 0, md_cyc = 0;
  bit          prev_busy = 0, gap_pending = 0;
  logic [1:0]  prev_step = '0;
  int          mc [2];
  logic [31:0] mm [2];

  always @(negedge clk) begin
    if (!resetn) begin
      prev_busy = 0; prev_step = '0; gap_pending = 0;
      mc[0] = 0; mc[1] = 0; mm[0] = '0; mm[1] = '0;
    end else begin
      cyc++;
      if (busy && !prev_busy) begin
        if (gap_pending) chk("load_gap", 64'(cyc - md_cyc), 64'd1);
        gap_pending = 0;
        load_cyc = cyc;
        mc[0] = 0; mc[1] = 0; mm[0] = '0; mm[1] = '0;
      end
      for (int a = 0; a < 2; a++) begin
        if (step[a] && !prev_step[a]) begin
          mc[a]++;
          if (sbq.size() != 0) begin
            int tk;
            tk = (cyc - load_cyc - 1) / sbq[0].div;
            if (tk >= 1 && tk <= 32) mm[a][tk-1] = 1'b1;
          end
        end
      end
      if (move_done) begin
        chk("done_expected", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("latency", 64'(cyc - load_cyc), 64'(e.lat));
          chk("steps_ax0", 64'(mc[0]), 64'(e.cnt0));
          chk("steps_ax1", 64'(mc[1]), 64'(e.cnt1));
          chk("ticks_ax0", 64'(mm[0]), 64'(e.mask0));
          chk("ticks_ax1", 64'(mm[1]), 64'(e.mask1));
          chk("dir", 64'(dir), 64'(e.dir));
        end
        md_cyc = cyc;
        gap_pending = (buffer_count != 0);
      end
      prev_busy = busy;
      prev_step = step;
    end
  end

  initial begin
    int w;
    bit ok;
    resetn = 1'b0; abort = 1'b0; wr_valid = 1'b0;
    wr_duration = '0; wr_dir = '0; wr_increment = '0; wr_incinc = '0;
    clock_divisor = 8'd4; cur_div = 4;
    macc[0] = 0; macc[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_step", 64'(step), 64'd0);
    chk("rst_dir", 64'(dir), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(move_done), 64'd0);
    chk("rst_count", 64'(buffer_count), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    resetn = 1'b1;

    // Basic move: axis0 every other tick, axis1 every tick.
    push_move(16'd10, 2'b01, 16'sd50, 16'sd0, 16'sd100, 16'sd0);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (step[0]) begin ok = 1; break; end
    end
    chk("wait_step0", 64'(ok), 64'd1);
    w = 0;
    while (step[0] && w < 20) begin w++; @(negedge clk); end
    chk("pulse_width", 64'(w), 64'd2);
    wait_idle();

    // Increment-increment only, then carried fractional accumulator.
    push_move(16'd4, 2'b10, 16'sd0, 16'sd10, 16'sd0, 16'sd0);
    push_move(16'd1, 2'b10, 16'sd60, 16'sd0, 16'sd0, 16'sd0);
    wait_idle();

    // Divisor 2 with overlapping pulses; divisor change after load is ignored.
    clock_divisor = 8'd2; cur_div = 2;
    push_move(16'd3, 2'b11, 16'sd50, 16'sd0, 16'sd100, -16'sd60);
    wait_busy();
    @(negedge clk);
    clock_divisor = 8'd4; cur_div = 4;
    wait_idle();

    // Fill the FIFO behind a long move.
    push_move(16'd20, 2'b00, 16'sd50, 16'sd0, 16'sd100, 16'sd0);
    wait_busy();
    for (int i = 0; i < 4; i++) push_move(16'd2, 2'(i), 16'sd30, 16'sd0, 16'sd70, 16'sd5);
    @(negedge clk); #1;
    chk("full_count", 64'(buffer_count), 64'd4);
    chk("full_wr_ready", 64'(wr_ready), 64'd0);
    wr_duration = 16'd3; wr_dir = 2'b11; wr_valid = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("held_count", 64'(buffer_count), 64'd4);
    chk("held_wr_ready", 64'(wr_ready), 64'd0);
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_md();
      @(negedge clk);
      chk("pop_count", 64'(buffer_count), 64'(3 - i));
    end
    wait_idle();

    // Zero-duration record between two normal moves.
    push_move(16'd2, 2'b00, 16'sd50, 16'sd0, 16'sd0, 16'sd0);
    push_move(16'd0, 2'b11, 16'sd100, 16'sd0, 16'sd100, 16'sd0);
    push_move(16'd2, 2'b01, 16'sd50, 16'sd0, 16'sd50, 16'sd0);
    wait_idle();

    // Abort mid-move with three entries queued; a same-cycle write is dropped.
    push_move(16'd30, 2'b10, 16'sd50, 16'sd0, 16'sd100, 16'sd0);
    wait_busy();
    for (int i = 0; i < 3; i++) push_move(16'd2, 2'b01, 16'sd40, 16'sd0, 16'sd40, 16'sd0);
    repeat (20) @(negedge clk);
    chk("pre_abort_count", 64'(buffer_count), 64'd3);
    @(negedge clk);
    abort = 1'b1; wr_valid = 1'b1; wr_duration = 16'd5;
    sbq.delete(); macc[0] = 0; macc[1] = 0;
    #1;
    chk("abort_wr_ready", 64'(wr_ready), 64'd0);
    @(negedge clk);
    abort = 1'b0; wr_valid = 1'b0;
    chk("abort_step", 64'(step), 64'd0);
    chk("abort_count", 64'(buffer_count), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(move_done), 64'd0);
    chk("abort_dir_hold", 64'(dir), 64'd2);
    repeat (10) @(negedge clk);
    chk("abort_stays_idle", 64'(busy), 64'd0);
    push_move(16'd1, 2'b01, 16'sd60, 16'sd0, 16'sd0, 16'sd0);
    wait_idle();

    // Asynchronous reset in the middle of a step pulse.
    push_move(16'd10, 2'b10, 16'sd0, 16'sd0, 16'sd100, 16'sd0);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (step[1]) begin ok = 1; break; end
    end
    chk("wait_step1", 64'(ok), 64'd1);
    #2 resetn = 1'b0;
    sbq.delete(); macc[0] = 0; macc[1] = 0;
    #1;
    chk("arst_step", 64'(step), 64'd0);
    chk("arst_dir", 64'(dir), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(move_done), 64'd0);
    chk("arst_count", 64'(buffer_count), 64'd0);
    chk("arst_wr_ready", 64'(wr_ready), 64'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("post_rst_wr_ready", 64'(wr_ready), 64'd1);
    ok = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (step != 2'b00 || busy) ok = 0;
    end
    chk("post_rst_quiet", 64'(ok), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
